// File: rtl/des_block_assembler.sv
// rtl/des_block_assembler.sv - DES input block assembler with initial permutation and output holding register
//
// Purpose:
//    First stage of the pipelined DES datapath. Serial bytes are gathered into a
//    64-bit block (first byte lands in block[63:56]), the block is optionally
//    passed through the DES initial permutation, and the resulting L0/R0 halves
//    are held in a one-deep output register so that assembly of the next block
//    overlaps consumption of the current one.
//
// Configuration:
//    DES_INIT_PERM_EN  when defined, {leftOut,rightOut} = IP(block); otherwise the
//                      block halves pass through unpermuted (a later stage does IP).
//    TIMEOUT_CYCLES    idle cycles tolerated inside a partial block; 0 disables.
//
// Ports:
//    clk          system clock, rising edge
//    rst_n        synchronous active-low reset
//    byteIn       received byte
//    byteValid    byteIn valid this cycle (1-cycle strobe)
//    outReady     downstream accepts the held block this cycle
//    leftOut      left half L0
//    rightOut     right half R0
//    blockValid   leftOut/rightOut hold an unconsumed block
//    timeoutErr   1-cycle pulse, partial block discarded by timeout
//    overflowErr  1-cycle pulse, completed block dropped because output was held

module des_block_assembler #(
   parameter int TIMEOUT_CYCLES = 1_000_000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [7:0]  byteIn,
   input  logic        byteValid,
   input  logic        outReady,
   output logic [31:0] leftOut,
   output logic [31:0] rightOut,
   output logic        blockValid,
   output logic        timeoutErr,
   output logic        overflowErr
);

   localparam int TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

   // Only the first seven bytes need storing: the eighth is taken straight
   // from byteIn in the completion cycle.
   logic [55:0]   shift_q;
   logic [2:0]    byte_count;
   logic [TW-1:0] idle_count;

   logic [63:0] block;
   logic [63:0] permuted;
   logic        complete;
   logic        slot_free;
   logic        load;
   logic        expire;

   assign block     = {shift_q, byteIn};
   assign complete  = byteValid && (byte_count == 3'd7);
   // The slot counts as free when it is being emptied in the same cycle.
   assign slot_free = !blockValid || outReady;
   assign load      = complete && slot_free;

`ifdef DES_INIT_PERM_EN
   // FIPS 46-3 IP. Rows 0..3 start at 58,60,62,64 and rows 4..7 at 57,59,61,63;
   // each column steps the source bit down by 8. Bit numbers are 1 = MSB.
   function automatic logic [63:0] init_perm(input logic [63:0] b);
      logic [63:0] o;
      int          src;
      o = '0;
      for (int r = 0; r < 8; r++) begin
         for (int c = 0; c < 8; c++) begin
            if (r < 4) src = 58 + 2 * r - 8 * c;
            else       src = 57 + 2 * (r - 4) - 8 * c;
            o[63 - (r * 8 + c)] = b[64 - src];
         end
      end
      return o;
   endfunction

   assign permuted = init_perm(block);
`else
   assign permuted = block;
`endif

   generate
      if (TIMEOUT_CYCLES > 0) begin : g_timeout
         localparam logic [TW-1:0] IDLE_LAST = TW'(TIMEOUT_CYCLES - 1);

         // Fires on the TIMEOUT_CYCLES-th consecutive idle cycle of a partial
         // block; a byte arriving in that cycle wins.
         assign expire = !byteValid && (byte_count != 3'd0) && (idle_count == IDLE_LAST);

         always_ff @(posedge clk) begin
            if (!rst_n) begin
               idle_count <= '0;
            end else if (byteValid || (byte_count == 3'd0) || expire) begin
               idle_count <= '0;
            end else begin
               idle_count <= idle_count + 1'b1;
            end
         end
      end else begin : g_no_timeout
         assign expire     = 1'b0;
         assign idle_count = '0;
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         shift_q     <= '0;
         byte_count  <= 3'd0;
         leftOut     <= '0;
         rightOut    <= '0;
         blockValid  <= 1'b0;
         timeoutErr  <= 1'b0;
         overflowErr <= 1'b0;
      end else begin
         timeoutErr  <= expire;
         overflowErr <= complete && !slot_free;

         if (byteValid) begin
            shift_q    <= block[55:0];
            // 3-bit counter wraps to 0 on the eighth byte by itself.
            byte_count <= byte_count + 3'd1;
         end else if (expire) begin
            shift_q    <= '0;
            byte_count <= 3'd0;
         end

         if (load) begin
            leftOut    <= permuted[63:32];
            rightOut   <= permuted[31:0];
            blockValid <= 1'b1;
         end else if (outReady) begin
            blockValid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_des_block_assembler.sv
// tb/tb_des_block_assembler.sv - self-checking bench for des_block_assembler

module tb_des_block_assembler;

   localparam int T = 10;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [7:0]  byteIn;
   logic        byteValid;
   logic        outReady;
   logic [31:0] leftOut;
   logic [31:0] rightOut;
   logic        blockValid;
   logic        timeoutErr;
   logic        overflowErr;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   des_block_assembler #(.TIMEOUT_CYCLES(T)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .byteIn      (byteIn),
      .byteValid   (byteValid),
      .outReady    (outReady),
      .leftOut     (leftOut),
      .rightOut    (rightOut),
      .blockValid  (blockValid),
      .timeoutErr  (timeoutErr),
      .overflowErr (overflowErr)
   );

   int ip_tab [64] = '{58,50,42,34,26,18,10,2,
                       60,52,44,36,28,20,12,4,
                       62,54,46,38,30,22,14,6,
                       64,56,48,40,32,24,16,8,
                       57,49,41,33,25,17, 9,1,
                       59,51,43,35,27,19,11,3,
                       61,53,45,37,29,21,13,5,
                       63,55,47,39,31,23,15,7};

   // reference model state
   logic [7:0]  mq [$];
   int          m_idle  = 0;
   logic        m_valid = 1'b0;
   logic        m_to    = 1'b0;
   logic        m_ov    = 1'b0;
   logic [63:0] m_out   = '0;

   function automatic logic [63:0] ref_perm(input logic [63:0] b);
      logic [63:0] o;
      o = b;
`ifdef DES_INIT_PERM_EN
      for (int i = 0; i < 64; i++) o[63 - i] = b[64 - ip_tab[i]];
`endif
      return o;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   task automatic model_step(input logic r, input logic bv, input logic [7:0] b, input logic ordy);
      logic        done;
      logic [63:0] blk;
      done = 1'b0;
      blk  = '0;
      m_to = 1'b0;
      m_ov = 1'b0;
      if (!r) begin
         mq.delete();
         m_idle  = 0;
         m_valid = 1'b0;
         m_out   = '0;
      end else begin
         if (bv) begin
            m_idle = 0;
            mq.push_back(b);
            if (mq.size() == 8) begin
               blk = {mq[0], mq[1], mq[2], mq[3], mq[4], mq[5], mq[6], mq[7]};
               mq.delete();
               done = 1'b1;
            end
         end else if (mq.size() != 0) begin
            m_idle++;
            if (m_idle == T) begin
               mq.delete();
               m_idle = 0;
               m_to   = 1'b1;
            end
         end
         if (done && (!m_valid || ordy)) begin
            m_out   = ref_perm(blk);
            m_valid = 1'b1;
         end else begin
            if (done) m_ov = 1'b1;
            if (m_valid && ordy) m_valid = 1'b0;
         end
      end
   endtask

   // Apply one cycle of inputs, advance the model, compare after the edge.
   task automatic cycle(input logic r, input logic bv, input logic [7:0] b, input logic ordy);
      rst_n     = r;
      byteValid = bv;
      byteIn    = b;
      outReady  = ordy;
      model_step(r, bv, b, ordy);
      @(posedge clk);
      #1;
      chk("model_valid", 64'(blockValid), 64'(m_valid));
      chk("model_timeout", 64'(timeoutErr), 64'(m_to));
      chk("model_overflow", 64'(overflowErr), 64'(m_ov));
      chk("model_data", {leftOut, rightOut}, m_out);
   endtask

   task automatic send_block(input logic [63:0] d, input logic ordy, input logic ordy_last);
      for (int k = 0; k < 8; k++)
         cycle(1'b1, 1'b1, d[63 - 8 * k -: 8], (k == 7) ? ordy_last : ordy);
   endtask

   typedef struct {
      logic [63:0] data;
      logic [31:0] l;
      logic [31:0] r;
   } vec_t;

   vec_t vt [5];

   initial begin
      logic [63:0] blk_a;
      logic [63:0] blk_b;
      logic [63:0] blk_c;
      int          p;

`ifdef DES_INIT_PERM_EN
      vt[0] = '{64'h0123456789ABCDEF, 32'hCC00CCFF, 32'hF0AAF0AA};
      vt[3] = '{64'h8000000000000000, 32'h00000000, 32'h01000000};
      vt[4] = '{64'h0000000000000001, 32'h00000080, 32'h00000000};
`else
      vt[0] = '{64'h0123456789ABCDEF, 32'h01234567, 32'h89ABCDEF};
      vt[3] = '{64'h8000000000000000, 32'h80000000, 32'h00000000};
      vt[4] = '{64'h0000000000000001, 32'h00000000, 32'h00000001};
`endif
      vt[1] = '{64'h0000000000000000, 32'h00000000, 32'h00000000};
      vt[2] = '{64'hFFFFFFFFFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};

      rst_n = 1'b0; byteValid = 1'b0; byteIn = 8'h00; outReady = 1'b0;
      cycle(1'b0, 1'b0, 8'h00, 1'b0);
      cycle(1'b0, 1'b0, 8'h00, 1'b0);
      chk("reset_outputs", {leftOut, rightOut, 29'd0, blockValid, timeoutErr, overflowErr}, 96'd0);

      // idle with outReady toggling
      for (int i = 0; i < 20; i++) begin
         cycle(1'b1, 1'b0, 8'h00, 1'(i & 1));
         chk("idle_outputs", {leftOut, rightOut}, 64'd0);
      end

      // table-driven single blocks, outReady=1
      for (int v = 0; v < 5; v++) begin
         send_block(vt[v].data, 1'b1, 1'b1);
         chk("vec_valid", 64'(blockValid), 64'd1);
         chk("vec_left", 64'(leftOut), 64'(vt[v].l));
         chk("vec_right", 64'(rightOut), 64'(vt[v].r));
         cycle(1'b1, 1'b0, 8'h00, 1'b1);
         chk("vec_valid_drop", 64'(blockValid), 64'd0);
      end

      // overflow: two blocks with outReady low
      blk_a = 64'h1122334455667788;
      blk_b = 64'hA5A55A5AC3C33C3C;
      send_block(blk_a, 1'b0, 1'b0);
      chk("ovf_first_valid", 64'(blockValid), 64'd1);
      send_block(blk_b, 1'b0, 1'b0);
      chk("ovf_pulse", 64'(overflowErr), 64'd1);
      chk("ovf_held", {leftOut, rightOut}, ref_perm(blk_a));
      cycle(1'b1, 1'b0, 8'h00, 1'b0);
      chk("ovf_once", 64'(overflowErr), 64'd0);
      chk("ovf_still_valid", 64'(blockValid), 64'd1);
      cycle(1'b1, 1'b0, 8'h00, 1'b1);
      chk("ovf_drained", 64'(blockValid), 64'd0);

      // reload in the transfer cycle
      send_block(blk_a, 1'b0, 1'b0);
      send_block(blk_b, 1'b0, 1'b1);
      chk("reload_no_ovf", 64'(overflowErr), 64'd0);
      chk("reload_valid", 64'(blockValid), 64'd1);
      chk("reload_data", {leftOut, rightOut}, ref_perm(blk_b));
      cycle(1'b1, 1'b0, 8'h00, 1'b1);

      // timeout after 3 bytes + 10 idle cycles
      for (int k = 0; k < 3; k++) cycle(1'b1, 1'b1, 8'(8'hE0 + k), 1'b1);
      for (int i = 1; i <= T; i++) begin
         cycle(1'b1, 1'b0, 8'h00, 1'b1);
         chk("timeout_pulse", 64'(timeoutErr), 64'(i == T));
      end
      cycle(1'b1, 1'b0, 8'h00, 1'b1);
      chk("timeout_once", 64'(timeoutErr), 64'd0);
      blk_c = 64'h0F1E2D3C4B5A6978;
      send_block(blk_c, 1'b1, 1'b1);
      chk("timeout_next_block", {leftOut, rightOut}, ref_perm(blk_c));
      cycle(1'b1, 1'b0, 8'h00, 1'b1);

      // byte on the 10th idle cycle keeps the block alive
      for (int k = 0; k < 3; k++) cycle(1'b1, 1'b1, 8'(8'h10 + k), 1'b1);
      for (int i = 1; i < T; i++) cycle(1'b1, 1'b0, 8'h00, 1'b1);
      cycle(1'b1, 1'b1, 8'h13, 1'b1);
      chk("late_byte_no_timeout", 64'(timeoutErr), 64'd0);
      for (int k = 4; k < 8; k++) cycle(1'b1, 1'b1, 8'(8'h10 + k), 1'b1);
      chk("late_byte_valid", 64'(blockValid), 64'd1);
      chk("late_byte_data", {leftOut, rightOut}, ref_perm(64'h1011121314151617));
      cycle(1'b1, 1'b0, 8'h00, 1'b1);

      // reset mid-block
      for (int k = 0; k < 5; k++) cycle(1'b1, 1'b1, 8'hBB, 1'b1);
      cycle(1'b0, 1'b0, 8'h00, 1'b1);
      chk("midreset_clear", {leftOut, rightOut, 61'd0, blockValid, timeoutErr, overflowErr}, 128'd0);
      send_block(64'h0123456789ABCDEF, 1'b1, 1'b1);
      chk("midreset_left", 64'(leftOut), 64'(vt[0].l));
      chk("midreset_right", 64'(rightOut), 64'(vt[0].r));

      // randomized traffic against the model
      p = 50;
      for (int n = 0; n < 3000; n++) begin
         if ((n % 64) == 0) p = $urandom_range(5, 95);
         cycle(($urandom_range(0, 299) != 0),
               ($urandom_range(0, 99) < p),
               8'($urandom),
               ($urandom_range(0, 3) != 0));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
